// File: rtl/fwperiph_dma_trace.sv
// fwperiph_dma_trace: captures DMA bus writes into a show-ahead trace buffer.
// Each accepted write stores {channel, address, data, timestamp}. When the
// buffer is full, further events are dropped and counted. A simultaneous pop
// frees a slot in the same cycle, so no event is dropped in that case.
// Optional feature macro: FWPERIPH_DMA_TRACE_TIMESTAMP_EN. When it is defined,
// a free-running 32-bit cycle counter is stamped into every entry. When it is
// undefined, there is no counter and rd_ts is tied to zero.
module fwperiph_dma_trace #(
  parameter int ch_count = 4,
  parameter int depth    = 16,
  parameter int cnt_w    = $clog2(depth) + 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [31:0]         adr,
  input  logic [31:0]         dat_w,
  input  logic [31:0]         we,
  input  logic [4:0]          ch_sel,
  input  logic                dma_busy,
  input  logic                trc_en,
  input  logic [ch_count-1:0] ch_en,
  input  logic                clear,
  output logic                rd_valid,
  input  logic                rd_ack,
  output logic [4:0]          rd_ch,
  output logic [31:0]         rd_adr,
  output logic [31:0]         rd_dat,
  output logic [31:0]         rd_ts,
  output logic [cnt_w-1:0]    level,
  output logic                ovf,
  output logic [15:0]         drop_cnt
);

  localparam int aw = $clog2(depth);
  localparam logic [5:0] ch_limit = 6'(ch_count);
  localparam logic [cnt_w-1:0] level_full = cnt_w'(depth);

  logic [aw-1:0] wr_ptr;
  logic [aw-1:0] rd_ptr;

  logic [4:0]  mem_ch  [depth];
  logic [31:0] mem_adr [depth];
  logic [31:0] mem_dat [depth];

  logic [31:0] en_mask;
  logic        ch_ok;
  logic        capture;
  logic        full;
  logic        pop;
  logic        push;
  logic        drop;

  // Widen the channel mask to 32 bits so any 5-bit ch_sel can index it safely
  always_comb begin
    en_mask = '0;
    en_mask[ch_count-1:0] = ch_en;
  end

  // Capture, push, pop and drop qualification; clear overrides everything
  always_comb begin
    ch_ok   = ({1'b0, ch_sel} < ch_limit) & en_mask[ch_sel];
    capture = trc_en & dma_busy & (|we) & ch_ok;
    full    = (level == level_full);
    pop     = rd_ack & rd_valid & ~clear;
    push    = capture & ~clear & (~full | pop);
    drop    = capture & ~clear & full & ~pop;
  end

  // Occupancy counter: moves only when exactly one of push/pop happens
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      level <= '0;
    end else if (clear) begin
      level <= '0;
    end else if (push && !pop) begin
      level <= level + cnt_w'(1);
    end else if (pop && !push) begin
      level <= level - cnt_w'(1);
    end
  end

  // Read and write pointers wrap naturally because depth is a power of two
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + aw'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + aw'(1);
      end
    end
  end

  // Sticky overflow flag and saturating drop counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (clear) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  // Entry storage is not reset; contents are meaningless while empty
  always_ff @(posedge clock) begin
    if (push) begin
      mem_ch[wr_ptr]  <= ch_sel;
      mem_adr[wr_ptr] <= adr;
      mem_dat[wr_ptr] <= dat_w;
    end
  end

  assign rd_valid = (level != '0);
  assign rd_ch    = mem_ch[rd_ptr];
  assign rd_adr   = mem_adr[rd_ptr];
  assign rd_dat   = mem_dat[rd_ptr];

`ifdef FWPERIPH_DMA_TRACE_TIMESTAMP_EN
  logic [31:0] ts_cnt;
  logic [31:0] mem_ts [depth];

  // Free-running cycle counter, wraps at 2^32
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ts_cnt <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
    end
  end

  // Timestamp column of the storage, written alongside the other fields
  always_ff @(posedge clock) begin
    if (push) begin
      mem_ts[wr_ptr] <= ts_cnt;
    end
  end

  assign rd_ts = mem_ts[rd_ptr];
`else
  assign rd_ts = 32'd0;
`endif

endmodule

// File: doc/fwperiph_dma_trace.md
FWPERIPH_DMA_TRACE -- requirements
Module: fwperiph_dma_trace

Interface
REQ-001 SHALL have parameter ch_count, default 4: number of DMA channels, 1..32.
REQ-002 SHALL have parameter depth, default 16: trace entries, power of two, 2..256.
REQ-003 SHALL have parameter cnt_w = $clog2(depth)+1, derived: width of level.
REQ-004 SHALL have one clock and an asynchronous active-low reset; ports listed below, clock and reset first.
REQ-005 clock  in  1  sole clock, rising edge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 adr  in  32  DMA bus write address.
REQ-008 dat_w  in  32  DMA bus write data.
REQ-009 we  in  32  write strobes; any bit set = write.
REQ-010 ch_sel  in  5  channel owning the current access.
REQ-011 dma_busy  in  1  engine active.
REQ-012 trc_en  in  1  global capture enable.
REQ-013 ch_en  in  ch_count  per-channel capture mask.
REQ-014 clear  in  1  synchronous flush pulse.
REQ-015 rd_valid  out  1  head entry available.
REQ-016 rd_ack  in  1  pop head entry.
REQ-017 rd_ch  out  5  head channel.
REQ-018 rd_adr  out  32  head address.
REQ-019 rd_dat  out  32  head data.
REQ-020 rd_ts  out  32  head timestamp.
REQ-021 level  out  cnt_w  entries held, 0..depth.
REQ-022 ovf  out  1  sticky overflow.
REQ-023 drop_cnt  out  16  dropped-event count.

Function
REQ-024 Capture event SHALL be: trc_en & dma_busy & |we & (ch_sel < ch_count) & ch_en[ch_sel], sampled at rising clock.
REQ-025 On event with level < depth, {ch_sel, adr, dat_w, ts} SHALL be written at tail; level increments next cycle.
REQ-026 On event with level == depth and no pop, event SHALL be dropped, ovf set, drop_cnt incremented, saturating at 0xFFFF.
REQ-027 Buffer SHALL be show-ahead: rd_valid = (level != 0); rd_* SHALL show head entry combinationally from storage.
REQ-028 rd_ack with rd_valid high SHALL pop head at that edge; rd_ack with rd_valid low SHALL be ignored.
REQ-029 Capture-to-rd_valid latency SHALL be 1 cycle from an empty buffer.
REQ-030 Simultaneous event and pop SHALL both take effect, level unchanged, even when full (no drop).
REQ-031 Read/write pointers SHALL wrap modulo depth; level SHALL never exceed depth or go below 0.
REQ-032 clear SHALL empty buffer, clear ovf and drop_cnt next cycle; clear SHALL override same-cycle event and pop.
REQ-033 ch_sel >= ch_count SHALL never capture nor count as a drop.
REQ-034 Storage contents SHALL not matter when empty; rd_* values are don't-care while rd_valid low.

Reset
REQ-035 reset_n low SHALL asynchronously force level=0, rd_valid=0, ovf=0, drop_cnt=0, pointers=0, timestamp=0.
REQ-036 Reset asserted mid-capture SHALL discard all entries; storage array itself need not be reset.
REQ-037 First capture SHALL be possible on first rising edge after reset_n deasserts.

Configuration
REQ-038 Macro FWPERIPH_DMA_TRACE_TIMESTAMP_EN SHALL select timestamping.
REQ-039 Defined: a 32-bit free-running counter, wrapping, increments every cycle from 0 after reset; captured value stored per entry and shown on rd_ts.
REQ-040 Undefined: no counter or timestamp storage; rd_ts SHALL be tied to 0; port list unchanged.

Verification
REQ-041 ch_count=4, depth=4: write ch2 adr=0x100 dat=0xA5A5A5A5 -> next cycle rd_valid=1, rd_ch=2, rd_adr=0x100, rd_dat=0xA5A5A5A5, level=1.
REQ-042 Six events, no reads, depth=4 -> level=4, ovf=1, drop_cnt=2; reads return first four in order.
REQ-043 Full buffer, event plus rd_ack same cycle -> level stays 4, drop_cnt unchanged, newest entry last out.
REQ-044 ch_en=4'b0101, events on ch0..3 plus ch_sel=7 -> only ch0, ch2 captured; drop_cnt=0.
REQ-045 clear with simultaneous event after overflow -> level=0, ovf=0, drop_cnt=0, rd_valid=0.
REQ-046 With TIMESTAMP_EN, events 3 cycles apart -> rd_ts delta=3; without it rd_ts=0; reset_n pulse mid-stream -> level=0 immediately.
